// File: rtl/eval_phase_blend.sv
// Phase-tapered blend of per-channel midgame/endgame evaluator scores.
// Collects enabled channel scores, then blends them via a 4-stage fixed-point pipeline.
module eval_phase_blend #(
    parameter int EVAL_WIDTH  = 24,
    parameter int CHANNELS    = 2,
    parameter int PHASE_MAX   = 62,
    parameter int RECIP_SHIFT = 20
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic [63:0]                      occupied,
    input  logic                             taper_enable,
    input  logic [CHANNELS-1:0]              chan_enable,
    input  logic [CHANNELS-1:0]              chan_valid,
    input  logic [CHANNELS*EVAL_WIDTH-1:0]   eval_mg_in,
    input  logic [CHANNELS*EVAL_WIDTH-1:0]   eval_eg_in,
    input  logic                             clear_eval,
    output logic signed [EVAL_WIDTH-1:0]     eval,
    output logic                             eval_valid,
    output logic [6:0]                       phase,
    output logic                             saturated,
    output logic                             busy
);

    localparam int SUMW = EVAL_WIDTH + $clog2(CHANNELS) + 1;
    localparam int TW   = SUMW + 8;
    localparam int RW   = RECIP_SHIFT + 2;
    localparam int PW   = TW + RW;

    localparam logic signed [RW-1:0] RECIP = RW'((64'd1 << RECIP_SHIFT) / 64'(PHASE_MAX));
    localparam logic signed [PW-1:0] BIAS  = {{(PW-RECIP_SHIFT){1'b0}}, {RECIP_SHIFT{1'b1}}};
    localparam logic signed [PW-1:0] EMAX  = {{(PW-EVAL_WIDTH+1){1'b0}}, {(EVAL_WIDTH-1){1'b1}}};
    localparam logic signed [PW-1:0] EMIN  = {{(PW-EVAL_WIDTH+1){1'b1}}, {(EVAL_WIDTH-1){1'b0}}};

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COLLECT = 2'd1;
    localparam logic [1:0] S_BLEND   = 2'd2;
    localparam logic [1:0] S_HOLD    = 2'd3;

    logic [1:0]                   r_state;
    logic                         r_start_q;
    logic                         r_armed;
    logic [63:0]                  r_occ;
    logic                         r_taper;
    logic [CHANNELS-1:0]          r_en;
    logic [CHANNELS-1:0]          r_done;
    logic signed [EVAL_WIDTH-1:0] r_mg [CHANNELS];
    logic signed [EVAL_WIDTH-1:0] r_eg [CHANNELS];
    logic [6:0]                   r_phase;
    logic [1:0]                   r_cnt;
    logic signed [EVAL_WIDTH-1:0] r_eval;
    logic                         r_eval_valid;
    logic                         r_sat;

    logic signed [SUMW-1:0]       r_mg_sum;
    logic signed [SUMW-1:0]       r_eg_sum;
    logic signed [TW-1:0]         r_t;
    logic signed [PW-1:0]         r_prod;

    logic                         w_start_edge;
    logic [CHANNELS-1:0]          w_take;
    logic [CHANNELS-1:0]          w_done_nx;
    logic                         w_all;
    logic [6:0]                   w_pop;
    logic [6:0]                   w_phase;
    logic signed [SUMW-1:0]       w_mg_sum;
    logic signed [SUMW-1:0]       w_eg_sum;
    logic signed [7:0]            w_ph;
    logic signed [7:0]            w_pinv;
    logic signed [TW-1:0]         w_t;
    logic signed [PW-1:0]         w_adj;
    logic signed [PW-1:0]         w_div;
    logic signed [EVAL_WIDTH-1:0] w_res;
    logic                         w_sat;

    // r_armed stays low until start is seen low, so a start held through reset is not an edge.
    assign w_start_edge = start & ~r_start_q & r_armed;
    assign w_take       = chan_valid & r_en & ~r_done;
    assign w_done_nx    = r_done | w_take;
    assign w_all        = ((w_done_nx & r_en) == r_en);

    always_comb begin
        w_pop = '0;
        for (int unsigned i = 0; i < 64; i++) begin
            w_pop = w_pop + 7'(r_occ[i]);
        end
        w_phase = (w_pop > 7'(PHASE_MAX)) ? 7'(PHASE_MAX) : w_pop;
    end

    always_comb begin
        w_mg_sum = '0;
        w_eg_sum = '0;
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            w_mg_sum = w_mg_sum + SUMW'(r_mg[k]);
            w_eg_sum = w_eg_sum + SUMW'(r_eg[k]);
        end
    end

    always_comb begin
        w_ph   = $signed({1'b0, r_phase});
        w_pinv = $signed(8'(PHASE_MAX)) - w_ph;
        w_t    = TW'(r_mg_sum) * TW'(w_ph) + TW'(r_eg_sum) * TW'(w_pinv);
    end

    // Bias negatives before the arithmetic shift so the quotient truncates toward zero.
    always_comb begin
        w_adj = r_prod[PW-1] ? (r_prod + BIAS) : r_prod;
        w_div = w_adj >>> RECIP_SHIFT;
        w_sat = 1'b0;
        w_res = w_div[EVAL_WIDTH-1:0];
        if (w_div > EMAX) begin
            w_sat = 1'b1;
            w_res = EMAX[EVAL_WIDTH-1:0];
        end else if (w_div < EMIN) begin
            w_sat = 1'b1;
            w_res = EMIN[EVAL_WIDTH-1:0];
        end
    end

    // Free-running datapath; the FSM only decides when its final stage is captured.
    always_ff @(posedge clk) begin
        r_mg_sum <= w_mg_sum;
        r_eg_sum <= w_eg_sum;
        r_t      <= r_taper ? w_t : TW'(r_mg_sum);
        r_prod   <= r_taper ? (PW'(r_t) * PW'(RECIP)) : (PW'(r_t) <<< RECIP_SHIFT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_start_q    <= 1'b0;
            r_armed      <= 1'b0;
            r_occ        <= '0;
            r_taper      <= 1'b0;
            r_en         <= '0;
            r_done       <= '0;
            r_phase      <= '0;
            r_cnt        <= '0;
            r_eval       <= '0;
            r_eval_valid <= 1'b0;
            r_sat        <= 1'b0;
            for (int unsigned k = 0; k < CHANNELS; k++) begin
                r_mg[k] <= '0;
                r_eg[k] <= '0;
            end
        end else begin
            r_start_q <= start;
            r_armed   <= r_armed | ~start;
            case (r_state)
                S_IDLE: begin
                    if (w_start_edge) begin
                        r_occ   <= occupied;
                        r_taper <= taper_enable;
                        r_en    <= chan_enable;
                        r_done  <= '0;
                        for (int unsigned k = 0; k < CHANNELS; k++) begin
                            r_mg[k] <= '0;
                            r_eg[k] <= '0;
                        end
                        r_state <= S_COLLECT;
                    end
                end
                S_COLLECT: begin
                    if (clear_eval) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_phase <= w_phase;
                        r_done  <= w_done_nx;
                        for (int unsigned k = 0; k < CHANNELS; k++) begin
                            if (w_take[k]) begin
                                r_mg[k] <= eval_mg_in[k*EVAL_WIDTH +: EVAL_WIDTH];
                                r_eg[k] <= eval_eg_in[k*EVAL_WIDTH +: EVAL_WIDTH];
                            end
                        end
                        if (w_all) begin
                            r_cnt   <= '0;
                            r_state <= S_BLEND;
                        end
                    end
                end
                S_BLEND: begin
                    if (clear_eval) begin
                        r_state <= S_IDLE;
                    end else if (r_cnt == 2'd3) begin
                        r_eval       <= w_res;
                        r_sat        <= w_sat;
                        r_eval_valid <= 1'b1;
                        r_state      <= S_HOLD;
                    end else begin
                        r_cnt <= r_cnt + 2'd1;
                    end
                end
                S_HOLD: begin
                    if (clear_eval) begin
                        r_eval_valid <= 1'b0;
                        r_state      <= S_IDLE;
                    end
                end
                default: begin
                    r_eval_valid <= 1'b0;
                    r_state      <= S_IDLE;
                end
            endcase
        end
    end

    assign eval       = r_eval;
    assign eval_valid = r_eval_valid;
    assign phase      = r_phase;
    assign saturated  = r_sat;
    assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_eval_phase_blend.sv
// Directed bench for eval_phase_blend: a 1-channel 24-bit instance and a 2-channel 16-bit instance.
module tb_eval_phase_blend;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        clear_eval;
    logic [63:0] occupied;
    logic        taper_enable;

    logic               a_start;
    logic [0:0]         a_en, a_valid;
    logic [23:0]        a_mg, a_eg;
    logic signed [23:0] a_eval;
    logic               a_ev, a_sat, a_busy;
    logic [6:0]         a_phase;

    logic               b_start;
    logic [1:0]         b_en, b_valid;
    logic [31:0]        b_mg, b_eg;
    logic signed [15:0] b_eval;
    logic               b_ev, b_sat, b_busy;
    logic [6:0]         b_phase;

    int n_cmp = 0;
    int n_bad = 0;

    eval_phase_blend #(.EVAL_WIDTH(24), .CHANNELS(1), .PHASE_MAX(62), .RECIP_SHIFT(20)) u_dut_a (
        .clk(clk), .reset(reset), .start(a_start), .occupied(occupied),
        .taper_enable(taper_enable), .chan_enable(a_en), .chan_valid(a_valid),
        .eval_mg_in(a_mg), .eval_eg_in(a_eg), .clear_eval(clear_eval),
        .eval(a_eval), .eval_valid(a_ev), .phase(a_phase), .saturated(a_sat), .busy(a_busy)
    );

    eval_phase_blend #(.EVAL_WIDTH(16), .CHANNELS(2), .PHASE_MAX(62), .RECIP_SHIFT(20)) u_dut_b (
        .clk(clk), .reset(reset), .start(b_start), .occupied(occupied),
        .taper_enable(taper_enable), .chan_enable(b_en), .chan_valid(b_valid),
        .eval_mg_in(b_mg), .eval_eg_in(b_eg), .clear_eval(clear_eval),
        .eval(b_eval), .eval_valid(b_ev), .phase(b_phase), .saturated(b_sat), .busy(b_busy)
    );

    task automatic check(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_a(input string tag, input int exp_lat);
        int cnt = 0;
        while (a_ev !== 1'b1 && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        check({tag, "_lat"}, cnt, exp_lat);
    endtask

    task automatic wait_b(input string tag, input int exp_lat);
        int cnt = 0;
        while (b_ev !== 1'b1 && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        check({tag, "_lat"}, cnt, exp_lat);
    endtask

    task automatic clear_b(input string tag);
        clear_eval = 1'b1;
        @(negedge clk);
        clear_eval = 1'b0;
        check({tag, "_clr_valid"}, b_ev, 0);
        check({tag, "_clr_busy"}, b_busy, 0);
    endtask

    task automatic a_run(input string tag, input int mg, input int eg,
                         input int exp_eval, input int exp_phase, input int exp_sat);
        @(negedge clk) a_start = 1'b1;
        @(negedge clk) a_start = 1'b0;
        a_mg = 24'(mg);
        a_eg = 24'(eg);
        a_valid = 1'b1;
        @(negedge clk) a_valid = 1'b0;
        wait_a(tag, 4);
        check({tag, "_eval"}, a_eval, exp_eval);
        check({tag, "_phase"}, a_phase, exp_phase);
        check({tag, "_sat"}, a_sat, exp_sat);
        repeat (2) @(negedge clk);
        check({tag, "_hold"}, a_eval, exp_eval);
        clear_eval = 1'b1;
        @(negedge clk) clear_eval = 1'b0;
        check({tag, "_clr_valid"}, a_ev, 0);
    endtask

    task automatic b_run(input string tag, input logic [1:0] en, input logic [1:0] vmask,
                         input int mg0, input int eg0, input int mg1, input int eg1,
                         input int exp_eval, input int exp_sat);
        b_en = en;
        @(negedge clk) b_start = 1'b1;
        @(negedge clk) b_start = 1'b0;
        b_mg = {16'(mg1), 16'(mg0)};
        b_eg = {16'(eg1), 16'(eg0)};
        b_valid = vmask;
        @(negedge clk) b_valid = 2'b00;
        wait_b(tag, 4);
        check({tag, "_eval"}, b_eval, exp_eval);
        check({tag, "_sat"}, b_sat, exp_sat);
        clear_b(tag);
    endtask

    initial begin
        reset = 1'b1; clear_eval = 1'b0; occupied = '0; taper_enable = 1'b0;
        a_start = 1'b0; a_en = 1'b1; a_valid = 1'b0; a_mg = '0; a_eg = '0;
        b_start = 1'b0; b_en = 2'b11; b_valid = 2'b00; b_mg = '0; b_eg = '0;
        #12;
        check("rst_eval", a_eval, 0);
        check("rst_valid", a_ev, 0);
        check("rst_phase", a_phase, 0);
        check("rst_sat", a_sat, 0);
        check("rst_busy_a", a_busy, 0);
        check("rst_busy_b", b_busy, 0);
        #11 reset = 1'b0;

        // single channel, taper on
        occupied = 64'h0000_0000_FFFF_FFFF;
        taper_enable = 1'b1;
        a_run("v1_pos", 100, 200, 148, 32, 0);
        a_run("v2_neg", -100, -200, -148, 32, 0);
        occupied = '1;
        a_run("v3_clamp_phase", 100, 0, 99, 62, 0);

        // start held high across a full cycle must not retrigger
        taper_enable = 1'b0;
        @(negedge clk) a_start = 1'b1;
        @(negedge clk) begin a_mg = 24'd1; a_eg = 24'd1; a_valid = 1'b1; end
        @(negedge clk) a_valid = 1'b0;
        wait_a("held_start", 4);
        check("held_start_eval", a_eval, 1);
        clear_eval = 1'b1;
        @(negedge clk) clear_eval = 1'b0;
        repeat (3) @(negedge clk);
        check("held_start_noretrig", a_busy, 0);

        // start high through reset counts only after it is seen low
        reset = 1'b1;
        @(negedge clk) reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_start_high_busy", a_busy, 0);
        a_start = 1'b0;
        @(negedge clk) a_start = 1'b1;
        @(negedge clk);
        check("rst_start_fresh_edge", a_busy, 1);
        a_start = 1'b0;
        clear_eval = 1'b1;
        @(negedge clk) clear_eval = 1'b0;
        check("abort_collect_a", a_busy, 0);

        // two channels, 16-bit saturation
        occupied = 64'h3FFF_FFFF_FFFF_FFFF;
        taper_enable = 1'b1;
        b_run("v4_satpos", 2'b11, 2'b11, 32767, 32767, 32767, 32767, 32767, 1);
        check("v4_phase", b_phase, 62);
        taper_enable = 1'b0;
        b_run("v4_satneg", 2'b11, 2'b11, -32768, 0, -32768, 0, -32768, 1);
        b_run("v5_ch1only", 2'b10, 2'b10, 7, 7, 50, 50, 50, 0);

        // staggered valids, sticky done bit ignores a later channel-0 pulse
        b_en = 2'b11;
        @(negedge clk) b_start = 1'b1;
        @(negedge clk) begin b_start = 1'b0; b_mg = {16'd0, 16'd10}; b_valid = 2'b01; end
        @(negedge clk) b_valid = 2'b00;
        @(negedge clk) begin b_mg = {16'd0, 16'd999}; b_valid = 2'b01; end
        @(negedge clk) begin b_mg = {16'd20, 16'd999}; b_valid = 2'b10; end
        @(negedge clk) b_valid = 2'b00;
        wait_b("stagger", 4);
        check("stagger_eval", b_eval, 30);
        clear_b("stagger");

        // no channels enabled: valid five cycles after entering COLLECT
        taper_enable = 1'b1;
        b_en = 2'b00;
        @(negedge clk) b_start = 1'b1;
        @(negedge clk) b_start = 1'b0;
        wait_b("v5_none", 5);
        check("v5_none_eval", b_eval, 0);
        check("v5_none_sat", b_sat, 0);
        clear_b("v5_none");

        // reset in BLEND
        taper_enable = 1'b0;
        b_en = 2'b11;
        @(negedge clk) b_start = 1'b1;
        @(negedge clk) begin b_start = 1'b0; b_mg = {16'd5, 16'd5}; b_valid = 2'b11; end
        @(negedge clk) b_valid = 2'b00;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        check("v6_rst_busy", b_busy, 0);
        check("v6_rst_valid", b_ev, 0);
        check("v6_rst_eval", b_eval, 0);
        @(negedge clk) reset = 1'b0;
        repeat (6) @(negedge clk);
        check("v6_rst_nopulse", b_ev, 0);
        b_run("v6_after_rst", 2'b11, 2'b11, 3, 0, 4, 0, 7, 0);

        // clear during COLLECT
        @(negedge clk) b_start = 1'b1;
        @(negedge clk) begin b_start = 1'b0; clear_eval = 1'b1; end
        @(negedge clk) clear_eval = 1'b0;
        check("v6_abort_busy", b_busy, 0);
        b_valid = 2'b11;
        @(negedge clk) b_valid = 2'b00;
        repeat (6) @(negedge clk);
        check("v6_abort_nopulse", b_ev, 0);
        b_run("v6_after_abort", 2'b11, 2'b11, -9, 0, 2, 0, -7, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
